// File: rtl/pb_event_decoder.sv
// Two-button push-button front end: synchronise, debounce, detect press/release/long-hold
// events per button, and steer a 2-bit display-mode register from those events.
module pb_event_decoder #(
    parameter int DB_COUNT   = 50000,
    parameter int LONG_COUNT = 25000000
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PB_SW1,
    input  logic       PB_SW2,
    output logic [1:0] PB_LVL,
    output logic [1:0] PB_PRESS,
    output logic [1:0] PB_RELEASE,
    output logic [1:0] PB_LONG,
    output logic [1:0] MODE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DB_PRESS,
        ST_PRESSED,
        ST_DB_REL
    } state_t;

    localparam logic [15:0] DB_LAST     = 16'(DB_COUNT - 1);
    localparam logic [24:0] HOLD_LAST   = 25'(LONG_COUNT - 1);
    localparam logic [24:0] HOLD_BEFORE = 25'(LONG_COUNT - 2);

    logic [1:0]  w_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    state_t      r_state    [2];
    logic [15:0] r_db_cnt   [2];
    logic [24:0] r_hold_cnt [2];
    logic        w_long_combo;

    assign w_raw = {PB_SW2, PB_SW1};

    // NOTE: synchroniser flops reset to 1 (released button), so leaving reset never looks like a press.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: all state here uses non-blocking assignments; later assignments to the same
    // register in the same edge (e.g. hold clear on press) override the earlier default.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b]    <= ST_IDLE;
                r_db_cnt[b]   <= '0;
                r_hold_cnt[b] <= '0;
            end
            PB_LVL     <= '0;
            PB_PRESS   <= '0;
            PB_RELEASE <= '0;
            PB_LONG    <= '0;
        end else begin
            PB_PRESS   <= '0;
            PB_RELEASE <= '0;
            PB_LONG    <= '0;
            for (int b = 0; b < 2; b++) begin
                // Hold time keeps accruing through a release bounce; saturation makes LONG one-shot.
                if ((r_state[b] == ST_PRESSED || r_state[b] == ST_DB_REL) &&
                    r_hold_cnt[b] != HOLD_LAST) begin
                    r_hold_cnt[b] <= r_hold_cnt[b] + 25'd1;
                    if (r_hold_cnt[b] == HOLD_BEFORE) PB_LONG[b] <= 1'b1;
                end
                case (r_state[b])
                    ST_IDLE: begin
                        if (!r_sync2[b]) begin
                            r_state[b]  <= ST_DB_PRESS;
                            r_db_cnt[b] <= '0;
                        end
                    end
                    ST_DB_PRESS: begin
                        if (r_sync2[b]) begin
                            r_state[b] <= ST_IDLE;
                        end else if (r_db_cnt[b] == DB_LAST) begin
                            r_state[b]    <= ST_PRESSED;
                            r_hold_cnt[b] <= '0;
                            PB_LVL[b]     <= 1'b1;
                            PB_PRESS[b]   <= 1'b1;
                        end else begin
                            r_db_cnt[b] <= r_db_cnt[b] + 16'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (r_sync2[b]) begin
                            r_state[b]  <= ST_DB_REL;
                            r_db_cnt[b] <= '0;
                        end
                    end
                    ST_DB_REL: begin
                        if (!r_sync2[b]) begin
                            r_state[b] <= ST_PRESSED;
                        end else if (r_db_cnt[b] == DB_LAST) begin
                            r_state[b]    <= ST_IDLE;
                            PB_LVL[b]     <= 1'b0;
                            PB_RELEASE[b] <= 1'b1;
                        end else begin
                            r_db_cnt[b] <= r_db_cnt[b] + 16'd1;
                        end
                    end
                    default: r_state[b] <= ST_IDLE;
                endcase
            end
        end
    end

    // A long hold on one button while the other is held (or both long together) forces mode 3.
    assign w_long_combo = (PB_LONG[0] & PB_LONG[1]) |
                          (PB_LONG[0] & PB_LVL[1])  |
                          (PB_LONG[1] & PB_LVL[0]);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            MODE <= 2'b00;
        end else if (w_long_combo) begin
            MODE <= 2'b11;
        end else if (PB_PRESS == 2'b01) begin
            MODE <= MODE + 2'd1;
        end else if (PB_PRESS == 2'b10) begin
            MODE <= MODE - 2'd1;
        end
    end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Scenario bench for pb_event_decoder (DB_COUNT=8, LONG_COUNT=32): expected pulses are queued
// with their edge number and matched by a negedge monitor; levels and MODE are checked inline.
module tb_pb_event_decoder;

    localparam int DB = 8;
    localparam int LG = 32;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int cyc;
        int kind;
        int btn;
    } exp_t;

    logic       CLK    = 1'b0;
    logic       RESETn = 1'b1;
    logic       PB_SW1 = 1'b1;
    logic       PB_SW2 = 1'b1;
    logic [1:0] PB_LVL;
    logic [1:0] PB_PRESS;
    logic [1:0] PB_RELEASE;
    logic [1:0] PB_LONG;
    logic [1:0] MODE;

    int   edge_cnt = 0;
    int   errors   = 0;
    int   checks   = 0;
    exp_t sb[$];

    pb_event_decoder #(.DB_COUNT(DB), .LONG_COUNT(LG)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .PB_SW1     (PB_SW1),
        .PB_SW2     (PB_SW2),
        .PB_LVL     (PB_LVL),
        .PB_PRESS   (PB_PRESS),
        .PB_RELEASE (PB_RELEASE),
        .PB_LONG    (PB_LONG),
        .MODE       (MODE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt++;

    function automatic string kname(int k);
        return (k == K_PRESS) ? "PB_PRESS" : (k == K_REL) ? "PB_RELEASE" : "PB_LONG";
    endfunction

    task automatic expect_ev(int cyc, int kind, int btn);
        exp_t t;
        t.cyc  = cyc;
        t.kind = kind;
        t.btn  = btn;
        sb.push_back(t);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge CLK);
    endtask

    // Every observed pulse consumes the oldest matching expectation and must land on its edge.
    always @(negedge CLK) begin
        logic [1:0] v;
        int idx;
        if (RESETn) begin
            for (int k = 0; k < 3; k++) begin
                v = (k == K_PRESS) ? PB_PRESS : (k == K_REL) ? PB_RELEASE : PB_LONG;
                for (int b = 0; b < 2; b++) begin
                    if (v[b]) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].kind == k && sb[i].btn == b) idx = i;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse: %s[%0d] high after edge %0d, required none",
                                     kname(k), b, edge_cnt);
                        end else begin
                            if (sb[idx].cyc != edge_cnt) begin
                                errors++;
                                $display("FAIL pulse_edge: %s[%0d] high after edge %0d, required after edge %0d",
                                         kname(k), b, edge_cnt, sb[idx].cyc);
                            end
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    task automatic sb_flush(string name, int n);
        step(n);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d pulses never seen (first %s[%0d] due after edge %0d), required 0",
                     name, sb.size(), kname(sb[0].kind), sb[0].btn, sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1 RESETn = 1'b0;
        #1;
        checks++;
        if ({PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE} !== 10'b0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b required %b",
                     {PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE}, 10'b0);
        end
        step(2);
        checks++;
        if ({PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE} !== 10'b0) begin
            errors++;
            $display("FAIL reset_clocked: outputs=%b required %b",
                     {PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE}, 10'b0);
        end
        RESETn = 1'b1;
        step(2);
    endtask

    task automatic test_press_sw1();
        int e;
        e = edge_cnt;
        PB_SW1 = 1'b0;
        expect_ev(e + DB + 3, K_PRESS, 0);
        step(DB + 4);
        checks++;
        if (PB_LVL !== 2'b01) begin
            errors++;
            $display("FAIL press1_lvl: PB_LVL=%b required %b", PB_LVL, 2'b01);
        end
        checks++;
        if (MODE !== 2'b01) begin
            errors++;
            $display("FAIL press1_mode: MODE=%b required %b", MODE, 2'b01);
        end
        e = edge_cnt;
        PB_SW1 = 1'b1;
        expect_ev(e + DB + 3, K_REL, 0);
        step(DB + 4);
        checks++;
        if (PB_LVL !== 2'b00) begin
            errors++;
            $display("FAIL release1_lvl: PB_LVL=%b required %b", PB_LVL, 2'b00);
        end
        sb_flush("press_sw1", 3);
    endtask

    task automatic test_glitch_sw2();
        for (int g = 0; g < 4; g++) begin
            PB_SW2 = 1'b0;
            step(5);
            checks++;
            if (PB_LVL[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_lvl: PB_LVL[1]=%b required 0 (glitch %0d)", PB_LVL[1], g);
            end
            PB_SW2 = 1'b1;
            step(3);
        end
        step(10);
        checks++;
        if (PB_LVL !== 2'b00 || MODE !== 2'b01) begin
            errors++;
            $display("FAIL glitch_end: PB_LVL=%b MODE=%b required 00 01", PB_LVL, MODE);
        end
        sb_flush("glitch_sw2", 1);
    endtask

    task automatic test_bounce_long();
        int e;
        e = edge_cnt;
        expect_ev(e + DB + 3, K_PRESS, 0);
        expect_ev(e + DB + 3 + LG - 1, K_LONG, 0);
        expect_ev(e + 60 + DB + 3, K_REL, 0);
        for (int i = 0; i < 60; i++) begin
            PB_SW1 = (i >= 20 && i <= 22);
            step(1);
            if (i == 24) begin
                checks++;
                if (PB_LVL[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_lvl: PB_LVL[0]=%b required 1", PB_LVL[0]);
                end
            end
        end
        PB_SW1 = 1'b1;
        step(DB + 4);
        checks++;
        if (PB_LVL !== 2'b00 || MODE !== 2'b10) begin
            errors++;
            $display("FAIL bounce_end: PB_LVL=%b MODE=%b required 00 10", PB_LVL, MODE);
        end
        sb_flush("bounce_long", 3);
    endtask

    task automatic test_sw2_mode();
        int e;
        logic [1:0] want;
        RESETn = 1'b0;
        #1;
        checks++;
        if (MODE !== 2'b00) begin
            errors++;
            $display("FAIL sw2_reset_mode: MODE=%b required 00", MODE);
        end
        step(2);
        RESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = edge_cnt;
            PB_SW2 = 1'b0;
            expect_ev(e + DB + 3, K_PRESS, 1);
            step(DB + 4);
            want = 2'(3 - k);
            checks++;
            if (MODE !== want) begin
                errors++;
                $display("FAIL sw2_mode_step%0d: MODE=%b required %b", k, MODE, want);
            end
            e = edge_cnt;
            PB_SW2 = 1'b1;
            expect_ev(e + DB + 3, K_REL, 1);
            step(DB + 6);
        end
        e = edge_cnt;
        PB_SW1 = 1'b0;
        PB_SW2 = 1'b0;
        expect_ev(e + DB + 3, K_PRESS, 0);
        expect_ev(e + DB + 3, K_PRESS, 1);
        step(DB + 4);
        checks++;
        if (MODE !== 2'b00 || PB_LVL !== 2'b11) begin
            errors++;
            $display("FAIL both_press: MODE=%b PB_LVL=%b required 00 11", MODE, PB_LVL);
        end
        e = edge_cnt;
        PB_SW1 = 1'b1;
        PB_SW2 = 1'b1;
        expect_ev(e + DB + 3, K_REL, 0);
        expect_ev(e + DB + 3, K_REL, 1);
        step(DB + 6);
        sb_flush("sw2_mode", 1);
    endtask

    task automatic test_both_long();
        int e;
        e = edge_cnt;
        PB_SW1 = 1'b0;
        PB_SW2 = 1'b0;
        expect_ev(e + DB + 3, K_PRESS, 0);
        expect_ev(e + DB + 3, K_PRESS, 1);
        expect_ev(e + DB + 3 + LG - 1, K_LONG, 0);
        expect_ev(e + DB + 3 + LG - 1, K_LONG, 1);
        step(DB + 3 + LG);
        checks++;
        if (MODE !== 2'b11 || PB_LVL !== 2'b11) begin
            errors++;
            $display("FAIL both_long: MODE=%b PB_LVL=%b required 11 11", MODE, PB_LVL);
        end
        e = edge_cnt;
        PB_SW1 = 1'b1;
        PB_SW2 = 1'b1;
        expect_ev(e + DB + 3, K_REL, 0);
        expect_ev(e + DB + 3, K_REL, 1);
        step(DB + 6);
        sb_flush("both_long", 1);
    endtask

    task automatic test_mode_wrap();
        int e;
        e = edge_cnt;
        PB_SW1 = 1'b0;
        expect_ev(e + DB + 3, K_PRESS, 0);
        step(DB + 4);
        checks++;
        if (MODE !== 2'b00) begin
            errors++;
            $display("FAIL wrap_up: MODE=%b required 00", MODE);
        end
        e = edge_cnt;
        PB_SW1 = 1'b1;
        expect_ev(e + DB + 3, K_REL, 0);
        step(DB + 6);
        e = edge_cnt;
        PB_SW2 = 1'b0;
        expect_ev(e + DB + 3, K_PRESS, 1);
        step(DB + 4);
        checks++;
        if (MODE !== 2'b11) begin
            errors++;
            $display("FAIL wrap_down: MODE=%b required 11", MODE);
        end
        e = edge_cnt;
        PB_SW2 = 1'b1;
        expect_ev(e + DB + 3, K_REL, 1);
        step(DB + 6);
        sb_flush("mode_wrap", 1);
    endtask

    task automatic test_reset_abort();
        int r;
        PB_SW1 = 1'b0;
        step(8);
        RESETn = 1'b0;
        #1;
        checks++;
        if ({PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE} !== 10'b0) begin
            errors++;
            $display("FAIL abort_reset: outputs=%b required %b",
                     {PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE}, 10'b0);
        end
        step(3);
        checks++;
        if ({PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE} !== 10'b0) begin
            errors++;
            $display("FAIL abort_held: outputs=%b required %b",
                     {PB_LVL, PB_PRESS, PB_RELEASE, PB_LONG, MODE}, 10'b0);
        end
        r = edge_cnt;
        RESETn = 1'b1;
        expect_ev(r + DB + 3, K_PRESS, 0);
        step(DB + 4);
        checks++;
        if (MODE !== 2'b01 || PB_LVL !== 2'b01) begin
            errors++;
            $display("FAIL abort_repress: MODE=%b PB_LVL=%b required 01 01", MODE, PB_LVL);
        end
        r = edge_cnt;
        PB_SW1 = 1'b1;
        expect_ev(r + DB + 3, K_REL, 0);
        step(DB + 6);
        sb_flush("reset_abort", 1);
    endtask

    initial begin
        test_reset();
        test_press_sw1();
        test_glitch_sw2();
        test_bounce_long();
        test_sw2_mode();
        test_both_long();
        test_mode_wrap();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
